act_buffer_pingpong_ctrl: RTL

- Sequencer for the 2-bank ping-pong activation buffer.
- Generates the write addresses for the producer (DMA/CPU) and the wide-read addresses for the multi-lane consumer, tile by tile.
- Toggles the bank-select only when the write bank holds a complete tile and the read bank is fully drained.
- Sits between the DMA, the activation buffer and the multi-lane unit; holds no data.

---
 rtl/act_buffer_pingpong_ctrl_pkg.sv | 26 ++
 rtl/act_buffer_pingpong_ctrl_if.sv | 29 ++
 rtl/act_buffer_pingpong_ctrl_tile_counter.sv | 39 +++
 rtl/act_buffer_pingpong_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/act_buffer_pingpong_ctrl_pkg.sv
// rtl/act_buffer_pingpong_ctrl_pkg.sv - shared types, defaults and config check for the ping-pong buffer sequencer
package act_buf_ctrl_pkg;

  localparam int DEF_DEPTH      = 16384;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_NUM_LANES  = 16;
  localparam int DEF_TILE_CNT_W = 16;
  localparam int CNT_W          = DEF_ADDR_WIDTH + 1;
  localparam int LANE_STEP      = DEF_NUM_LANES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A tile must be a whole number of wide beats and fit inside one bank.
  function automatic logic cfg_legal(input int unsigned tile_words,
                                     input int unsigned num_tiles,
                                     input int unsigned depth,
                                     input int unsigned lanes);
    return (tile_words != 0) && ((tile_words % lanes) == 0) &&
           (tile_words <= depth) && (num_tiles != 0);
  endfunction

endpackage

// File: rtl/act_buffer_pingpong_ctrl_if.sv
// rtl/act_buffer_pingpong_ctrl_if.sv - producer, consumer and buffer-side signals of the sequencer
interface act_buf_ctrl_if
  import act_buf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  prod_valid;
  logic                  prod_ready;
  logic                  cons_req;
  logic                  cons_grant;
  logic                  cons_last;
  logic                  buf_ping_pong_sel;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic                  buf_wide_rd_en;
  logic [ADDR_WIDTH-1:0] buf_wide_rd_addr;

  modport master (
    input  prod_valid, cons_req,
    output prod_ready, cons_grant, cons_last, buf_ping_pong_sel,
           buf_wr_en, buf_wr_addr, buf_wide_rd_en, buf_wide_rd_addr
  );

  modport slave (
    output prod_valid, cons_req,
    input  prod_ready, cons_grant, cons_last, buf_ping_pong_sel,
           buf_wr_en, buf_wr_addr, buf_wide_rd_en, buf_wide_rd_addr
  );
endinterface

// File: rtl/act_buffer_pingpong_ctrl_tile_counter.sv
// rtl/act_buffer_pingpong_ctrl_tile_counter.sv - step counter that wraps to zero after reaching its limit
module act_buf_tile_counter
  import act_buf_ctrl_pkg::*;
#(
  parameter int CW   = CNT_W,
  parameter int STEP = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == limit_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last_o ? '0 : cnt_q + CW'(STEP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/act_buffer_pingpong_ctrl.sv
// rtl/act_buffer_pingpong_ctrl.sv - tile sequencer for the two-bank ping-pong activation buffer
module act_buffer_pingpong_ctrl
  import act_buf_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int TILE_CNT_W = DEF_TILE_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   cfg_tile_words_i,
  input  logic [TILE_CNT_W-1:0] cfg_num_tiles_i,
  act_buf_ctrl_if.master        bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int CW = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  fill_full_q, fill_full_d;
  logic                  rd_full_q, rd_full_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [CW-1:0]         tile_words_q, tile_words_d;
  logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_CNT_W-1:0] tiles_filled_q, tiles_filled_d;
  logic [TILE_CNT_W-1:0] tiles_drained_q, tiles_drained_d;

  logic          cfg_ok, start_ok, run;
  logic          prod_ready, wr_fire, grant, swap;
  logic          wr_last, rd_last;
  logic [CW-1:0] wr_cnt, rd_cnt, wr_limit, rd_limit;
  logic          unused_cnt_msb;

  assign cfg_ok   = cfg_legal(32'(cfg_tile_words_i), 32'(cfg_num_tiles_i),
                              DEPTH, NUM_LANES);
  assign start_ok = (state_q == ST_IDLE) && start_i && cfg_ok;

  // Enables are gated by rst_ni so nothing touches the buffer during the reset cycle.
  assign run        = rst_ni && (state_q == ST_RUN);
  assign prod_ready = run && !fill_full_q && (tiles_filled_q < num_tiles_q);
  assign wr_fire    = bus.prod_valid && prod_ready;
  assign grant      = run && rd_full_q && bus.cons_req;
  assign swap       = run && fill_full_q && !rd_full_q;

  assign wr_limit = tile_words_q - CW'(1);
  assign rd_limit = tile_words_q - CW'(NUM_LANES);

  act_buf_tile_counter #(.CW(CW), .STEP(1)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_ok),
    .adv_i   (wr_fire),
    .limit_i (wr_limit),
    .cnt_o   (wr_cnt),
    .last_o  (wr_last)
  );

  act_buf_tile_counter #(.CW(CW), .STEP(NUM_LANES)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_ok),
    .adv_i   (grant),
    .limit_i (rd_limit),
    .cnt_o   (rd_cnt),
    .last_o  (rd_last)
  );

  // Counters never exceed tile_words-1 <= DEPTH-1, so the top bit is never an address bit.
  assign unused_cnt_msb = wr_cnt[CW-1] ^ rd_cnt[CW-1];

  assign bus.prod_ready        = prod_ready;
  assign bus.buf_wr_en         = wr_fire;
  assign bus.buf_wr_addr       = wr_cnt[ADDR_WIDTH-1:0];
  assign bus.cons_grant        = grant;
  assign bus.buf_wide_rd_en    = grant;
  assign bus.buf_wide_rd_addr  = rd_cnt[ADDR_WIDTH-1:0];
  assign bus.cons_last         = grant && rd_last;
  assign bus.buf_ping_pong_sel = sel_q;

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign cfg_err_o = cfg_err_q;

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    fill_full_d     = fill_full_q;
    rd_full_d       = rd_full_q;
    cfg_err_d       = 1'b0;
    tile_words_d    = tile_words_q;
    num_tiles_d     = num_tiles_q;
    tiles_filled_d  = tiles_filled_q;
    tiles_drained_d = tiles_drained_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d         = ST_RUN;
            sel_d           = 1'b0;
            fill_full_d     = 1'b0;
            rd_full_d       = 1'b0;
            tile_words_d    = cfg_tile_words_i;
            num_tiles_d     = cfg_num_tiles_i;
            tiles_filled_d  = '0;
            tiles_drained_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (wr_fire && wr_last) begin
          fill_full_d    = 1'b1;
          tiles_filled_d = tiles_filled_q + 1'b1;
        end
        if (grant && rd_last) begin
          rd_full_d       = 1'b0;
          tiles_drained_d = tiles_drained_q + 1'b1;
        end
        // Swap only fires with fill_full=1 and rd_full=0, so it never overlaps an access.
        if (swap) begin
          sel_d       = ~sel_q;
          rd_full_d   = 1'b1;
          fill_full_d = 1'b0;
        end
        if (tiles_drained_q == num_tiles_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      sel_q           <= 1'b0;
      fill_full_q     <= 1'b0;
      rd_full_q       <= 1'b0;
      cfg_err_q       <= 1'b0;
      tile_words_q    <= '0;
      num_tiles_q     <= '0;
      tiles_filled_q  <= '0;
      tiles_drained_q <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      fill_full_q     <= fill_full_d;
      rd_full_q       <= rd_full_d;
      cfg_err_q       <= cfg_err_d;
      tile_words_q    <= tile_words_d;
      num_tiles_q     <= num_tiles_d;
      tiles_filled_q  <= tiles_filled_d;
      tiles_drained_q <= tiles_drained_d;
    end
  end

endmodule
